// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: state codes, opcodes, ALU selects.
// Pure declarations, no logic.
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        S_IFETCH = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b100000;
    localparam logic [5:0] OPC_LI    = 6'b111000;
    localparam logic [5:0] OPC_ADDI  = 6'b110000;
    localparam logic [5:0] OPC_B     = 6'b111111;
    localparam logic [5:0] OPC_BEQ   = 6'b000000;
    localparam logic [5:0] OPC_BNE   = 6'b000001;
    localparam logic [5:0] OPC_LW    = 6'b001111;
    localparam logic [5:0] OPC_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned WAIT_W          = 8;

    typedef enum logic [3:0] {
        C_RTYPE, C_LI, C_ADDI, C_B, C_BEQ, C_BNE, C_LW, C_SW, C_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] opc);
        case (opc)
            OPC_RTYPE: return C_RTYPE;
            OPC_LI:    return C_LI;
            OPC_ADDI:  return C_ADDI;
            OPC_B:     return C_B;
            OPC_BEQ:   return C_BEQ;
            OPC_BNE:   return C_BNE;
            OPC_LW:    return C_LW;
            OPC_SW:    return C_SW;
            default:   return C_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_seq_timeout_cnt.sv
// Memory-wait counter: clears on clr, counts on inc, flags the last permitted wait cycle.
// Latency: term is combinational from the registered count; no backpressure.
module multicycle_seq_timeout_cnt
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted during the LIMIT-th consecutive wait cycle.
    assign term = (cnt == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle CPU control sequencer: IFETCH/DECODE/EXEC/MEM/WB with sticky FAULT.
// Latency: branch 3, ALU/li/addi/sw 4, lw 5 cycles plus memory waits; Mem_Ack stalls IFETCH/MEM.
// Optional MULTICYCLE_SEQ_PERF_EN adds Cycle_Cnt/Instr_Cnt performance counters.
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Mem_Ack,
    output logic        Mem_Req,
    output logic        PC_Sel,
    output logic        PC_LdEn,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic        Mem_WrEn,
    output logic [3:0]  ALU_func,
    output logic        Fault,
`ifdef MULTICYCLE_SEQ_PERF_EN
    output logic [31:0] Cycle_Cnt,
    output logic [31:0] Instr_Cnt,
`endif
    output logic [2:0]  State
);

    state_t    state;
    state_t    next_state;
    op_class_t op;
    logic      branch_taken;
    logic      wait_en;
    logic      wait_clr;
    logic      wait_term;
    logic      unused_instr_bits;

    assign op                = classify(Instr[31:26]);
    assign unused_instr_bits = ^Instr[25:4];
    assign branch_taken      = (op == C_B) || ((op == C_BEQ) && Zero) || ((op == C_BNE) && !Zero);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IFETCH;
        end else begin
            state <= next_state;
        end
    end

    // Wait time is per state visit, so any transition restarts the count.
    assign wait_en  = ((state == S_IFETCH) || (state == S_MEM)) && !Mem_Ack;
    assign wait_clr = Reset || (next_state != state);

    multicycle_seq_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wait (
        .clk  (Clk),
        .clr  (wait_clr),
        .inc  (wait_en),
        .term (wait_term)
    );

    always_comb begin
        next_state    = state;
        Mem_Req       = 1'b0;
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        Mem_WrEn      = 1'b0;
        ALU_func      = ALU_ADD;
        case (state)
            S_IFETCH: begin
                Mem_Req = 1'b1;
                if (Mem_Ack) begin
                    IR_LdEn    = 1'b1;
                    PC_LdEn    = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_term) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                next_state = (op == C_ILLEGAL) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    C_RTYPE: begin
                        ALU_func   = Instr[3:0];
                        next_state = S_WB;
                    end
                    C_LI, C_ADDI: begin
                        ALU_Bin_sel = 1'b1;
                        next_state  = S_WB;
                    end
                    C_LW: begin
                        ALU_Bin_sel = 1'b1;
                        next_state  = S_MEM;
                    end
                    C_SW: begin
                        ALU_Bin_sel = 1'b1;
                        RF_B_sel    = 1'b1;
                        next_state  = S_MEM;
                    end
                    C_B, C_BEQ, C_BNE: begin
                        ALU_func   = ALU_SUB;
                        PC_LdEn    = branch_taken;
                        PC_Sel     = branch_taken;
                        next_state = S_IFETCH;
                    end
                    default: next_state = S_FAULT;
                endcase
            end
            S_MEM: begin
                Mem_Req  = 1'b1;
                Mem_WrEn = (op == C_SW);
                if (Mem_Ack) begin
                    next_state = (op == C_SW) ? S_IFETCH : S_WB;
                end else if (wait_term) begin
                    next_state = S_FAULT;
                end
            end
            S_WB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = (op == C_LW);
                next_state    = S_IFETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
    end

    assign Fault = (state == S_FAULT);
    assign State = state;

`ifdef MULTICYCLE_SEQ_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Cycle_Cnt <= '0;
            Instr_Cnt <= '0;
        end else begin
            if (state != S_FAULT) begin
                Cycle_Cnt <= Cycle_Cnt + 1'b1;
            end
            if ((next_state == S_IFETCH) && (state != S_IFETCH)) begin
                Instr_Cnt <= Instr_Cnt + 1'b1;
            end
        end
    end
`else
    // Counters are compiled out entirely in the default build.
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: table of instruction vectors, reset/timeout corner sequences,
// and randomized instruction streams checked cycle by cycle against a phase-list model.
module tb_multicycle_seq;

    localparam int TMO = 16;

    localparam logic [5:0] T_R    = 6'b100000;
    localparam logic [5:0] T_LI   = 6'b111000;
    localparam logic [5:0] T_ADDI = 6'b110000;
    localparam logic [5:0] T_B    = 6'b111111;
    localparam logic [5:0] T_BEQ  = 6'b000000;
    localparam logic [5:0] T_BNE  = 6'b000001;
    localparam logic [5:0] T_LW   = 6'b001111;
    localparam logic [5:0] T_SW   = 6'b011111;
    localparam logic [5:0] T_BAD  = 6'b101010;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        Mem_Ack;
    logic        Mem_Req, PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel;
    logic        RF_B_sel, ALU_Bin_sel, Mem_WrEn, Fault;
    logic [3:0]  ALU_func;
    logic [2:0]  State;
`ifdef MULTICYCLE_SEQ_PERF_EN
    logic [31:0] Cycle_Cnt;
    logic [31:0] Instr_Cnt;
`endif

    multicycle_seq #(.TIMEOUT(TMO)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .Zero          (Zero),
        .Mem_Ack       (Mem_Ack),
        .Mem_Req       (Mem_Req),
        .PC_Sel        (PC_Sel),
        .PC_LdEn       (PC_LdEn),
        .IR_LdEn       (IR_LdEn),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .Mem_WrEn      (Mem_WrEn),
        .ALU_func      (ALU_func),
        .Fault         (Fault),
`ifdef MULTICYCLE_SEQ_PERF_EN
        .Cycle_Cnt     (Cycle_Cnt),
        .Instr_Cnt     (Instr_Cnt),
`endif
        .State         (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: expected state per cycle, and Mem_Ack to drive (0/1, 2 = don't care -> random)
    int ph[$];
    int ak[$];

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          fw;
        int          mw;
        int          exp_cycles;
        logic        exp_taken;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] f);
        logic [21:0] mid;
        mid = 22'($urandom);
        return {op, mid, f};
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {T_R, T_LI, T_ADDI, T_B, T_BEQ, T_BNE, T_LW, T_SW};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {State, Mem_Req, PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel,
                RF_B_sel, ALU_Bin_sel, Mem_WrEn, ALU_func, Fault};
    endfunction

    // Expected control outputs for a given state, straight from the per-state rules
    function automatic logic [16:0] exp_vec(input int st, input logic [31:0] ins,
                                            input logic z, input logic ack);
        logic mreq, psel, pld, irld, rfw, rfd, rfb, bin, mwr, flt;
        logic [3:0] fn;
        logic [5:0] op;
        op = ins[31:26];
        {mreq, psel, pld, irld, rfw, rfd, rfb, bin, mwr, flt} = '0;
        fn = 4'b0000;
        case (st)
            0: begin mreq = 1'b1; irld = ack; pld = ack; end
            2: begin
                if (op == T_R) fn = ins[3:0];
                else if (op inside {T_LI, T_ADDI, T_LW}) bin = 1'b1;
                else if (op == T_SW) begin bin = 1'b1; rfb = 1'b1; end
                else if (op inside {T_B, T_BEQ, T_BNE}) begin
                    fn   = 4'b0001;
                    pld  = (op == T_B) || (op == T_BEQ && z) || (op == T_BNE && !z);
                    psel = pld;
                end
            end
            3: begin mreq = 1'b1; mwr = (op == T_SW); end
            4: begin rfw = 1'b1; rfd = (op == T_LW); end
            7: flt = 1'b1;
            default: ;
        endcase
        return {3'(st), mreq, psel, pld, irld, rfw, rfd, rfb, bin, mwr, fn, flt};
    endfunction

    function automatic void push_fault();
        for (int i = 0; i < 3; i++) begin ph.push_back(7); ak.push_back(2); end
    endfunction

    // Phase list for one instruction given fetch and memory wait lengths
    function automatic void build(input logic [5:0] op, input int fw, input int mw);
        ph.delete();
        ak.delete();
        if (fw >= TMO) begin
            for (int i = 0; i < TMO; i++) begin ph.push_back(0); ak.push_back(0); end
            push_fault();
            return;
        end
        for (int i = 0; i <= fw; i++) begin ph.push_back(0); ak.push_back(i == fw ? 1 : 0); end
        ph.push_back(1); ak.push_back(2);
        if (!legal(op)) begin push_fault(); return; end
        ph.push_back(2); ak.push_back(2);
        if (op == T_LW || op == T_SW) begin
            if (mw >= TMO) begin
                for (int i = 0; i < TMO; i++) begin ph.push_back(3); ak.push_back(0); end
                push_fault();
                return;
            end
            for (int i = 0; i <= mw; i++) begin ph.push_back(3); ak.push_back(i == mw ? 1 : 0); end
        end
        if (op inside {T_R, T_LI, T_ADDI, T_LW}) begin ph.push_back(4); ak.push_back(2); end
    endfunction

    task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw,
                             output int cyc, output logic tk);
        int   n;
        int   st;
        logic left;
        build(ins[31:26], fw, mw);
        n    = ph.size();
        cyc  = -1;
        tk   = 1'b0;
        left = 1'b0;
        for (int k = 0; k <= n; k++) begin
            Instr = ins;
            Zero  = z;
            if (k < n) begin
                Mem_Ack = (ak[k] == 2) ? 1'($urandom_range(0, 1)) : (ak[k] == 1);
                st      = ph[k];
            end else begin
                Mem_Ack = 1'b0;
                st      = (ph[n-1] == 7) ? 7 : 0;
            end
            #1;
            if (State != 3'd0) left = 1'b1;
            else if (left && cyc < 0) cyc = k;
            if (State == 3'd2 && PC_LdEn && PC_Sel) tk = 1'b1;
            chk("cycle_outputs", 32'(dut_vec()), 32'(exp_vec(st, ins, z, Mem_Ack)));
            if (k < n) step();
        end
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Mem_Ack = 1'($urandom_range(0, 1));
        step();
        Reset   = 1'b0;
        Mem_Ack = 1'b0;
        #1;
        chk("reset_outputs", 32'(dut_vec()), 32'(exp_vec(0, Instr, Zero, 1'b0)));
    endtask

    initial begin
        int          cyc;
        logic        tk;
        logic [5:0]  ops[9];
        logic [31:0] ins;

        Reset   = 1'b1;
        Instr   = '0;
        Zero    = 1'b0;
        Mem_Ack = 1'b0;

        tbl[0]  = '{mk(T_R,    4'hA), 1'b0, 0,  0,  4,  1'b0};
        tbl[1]  = '{mk(T_BEQ,  4'h3), 1'b1, 0,  0,  3,  1'b1};
        tbl[2]  = '{mk(T_BEQ,  4'h3), 1'b0, 0,  0,  3,  1'b0};
        tbl[3]  = '{mk(T_BNE,  4'h0), 1'b0, 0,  0,  3,  1'b1};
        tbl[4]  = '{mk(T_BNE,  4'h0), 1'b1, 0,  0,  3,  1'b0};
        tbl[5]  = '{mk(T_B,    4'h7), 1'b0, 0,  0,  3,  1'b1};
        tbl[6]  = '{mk(T_LI,   4'h5), 1'b0, 0,  0,  4,  1'b0};
        tbl[7]  = '{mk(T_ADDI, 4'h9), 1'b1, 0,  0,  4,  1'b0};
        tbl[8]  = '{mk(T_SW,   4'h1), 1'b0, 0,  0,  4,  1'b0};
        tbl[9]  = '{mk(T_LW,   4'h2), 1'b0, 0,  0,  5,  1'b0};
        tbl[10] = '{mk(T_LW,   4'h2), 1'b0, 0,  3,  8,  1'b0};
        tbl[11] = '{mk(T_R,    4'h6), 1'b1, 2,  0,  6,  1'b0};
        tbl[12] = '{mk(T_R,    4'hF), 1'b0, 15, 0,  19, 1'b0};
        tbl[13] = '{mk(T_SW,   4'h4), 1'b0, 0,  15, 19, 1'b0};
        tbl[14] = '{mk(T_BAD,  4'h0), 1'b0, 0,  0,  -1, 1'b0};
        tbl[15] = '{mk(T_R,    4'h1), 1'b0, 16, 0,  -1, 1'b0};
        tbl[16] = '{mk(T_LW,   4'h2), 1'b0, 0,  16, -1, 1'b0};

        step();
        step();
        do_reset();

        for (int i = 0; i < 17; i++) begin
            run_instr(tbl[i].instr, tbl[i].zero, tbl[i].fw, tbl[i].mw, cyc, tk);
            chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cycles));
            chk($sformatf("tbl%0d_taken", i), 32'(tk), 32'(tbl[i].exp_taken));
            if (tbl[i].exp_cycles < 0) begin
                chk($sformatf("tbl%0d_fault", i), 32'(Fault), 32'd1);
                do_reset();
            end
        end

        // Reset and timeout collide in the same cycle: reset must win
        do_reset();
        for (int i = 0; i < TMO - 1; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        chk("reset_beats_timeout_state", 32'(State), 32'd0);
        chk("reset_beats_timeout_fault", 32'(Fault), 32'd0);
        run_instr(mk(T_R, 4'h3), 1'b0, TMO - 1, 0, cyc, tk);
        chk("post_collide_cycles", 32'(cyc), 32'(TMO + 3));

        // Reset during a store's memory wait, with Mem_Ack raised alongside
        do_reset();
        ins     = mk(T_SW, 4'h0);
        Instr   = ins;
        Mem_Ack = 1'b1;
        step();
        Mem_Ack = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) step();
        #1;
        chk("sw_mem_wait_state", 32'(State), 32'd3);
        chk("sw_mem_wait_wren", 32'(Mem_WrEn), 32'd1);
        Reset   = 1'b1;
        Mem_Ack = 1'b1;
        step();
        Reset   = 1'b0;
        Mem_Ack = 1'b0;
        #1;
        chk("sw_reset_outputs", 32'(dut_vec()), 32'(exp_vec(0, ins, Zero, 1'b0)));
        chk("sw_reset_wren", 32'(Mem_WrEn), 32'd0);
        run_instr(mk(T_R, 4'h8), 1'b1, TMO - 1, 0, cyc, tk);
        chk("post_sw_reset_cycles", 32'(cyc), 32'(TMO + 3));

`ifdef MULTICYCLE_SEQ_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(mk(T_R, 4'h2), 1'b0, 0, 0, cyc, tk);
        chk("perf_instr_cnt", Instr_Cnt, 32'd3);
        chk("perf_cycle_cnt", Cycle_Cnt, 32'd12);
`endif

        // Randomized instruction stream
        ops = '{T_R, T_LI, T_ADDI, T_B, T_BEQ, T_BNE, T_LW, T_SW, T_BAD};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            ins = mk(ops[$urandom_range(0, 8)], 4'($urandom));
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), cyc, tk);
            if (ph[ph.size()-1] == 7) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles to wait for Mem_Ack before faulting, range 2..255.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Instr  in  32  instruction register contents; opcode Instr[31:26], R-type func Instr[3:0].
REQ-005 Zero  in  1  ALU zero flag from the datapath.
REQ-006 Mem_Ack  in  1  memory transfer complete, sampled in IFETCH/MEM.
REQ-007 Mem_Req  out  1  memory access request.
REQ-008 PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Mem_WrEn  out  1 each  datapath controls.
REQ-009 ALU_func  out  4  ALU operation select.
REQ-010 Fault  out  1  sticky illegal-opcode or memory-timeout indication.
REQ-011 State  out  3  current FSM state code, debug only.

Function
REQ-012 SHALL be a Moore FSM; state codes: IFETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
REQ-013 IFETCH: Mem_Req=1; on Mem_Ack, IR_LdEn=1 and PC_LdEn=1 with PC_Sel=0 (PC+4) in that cycle, then DECODE.
REQ-014 DECODE: one cycle; opcode classified: 100000 R-type, 111000 li, 110000 addi, 111111 b, 000000 beq, 000001 bne, 001111 lw, 011111 sw; any other -> FAULT.
REQ-015 EXEC: R-type ALU_func=Instr[3:0], ALU_Bin_sel=0; li/addi/lw/sw ALU_func=0000 (add), ALU_Bin_sel=1; sw also RF_B_sel=1.
REQ-016 Branch in EXEC: ALU_func=0001 (sub); PC_LdEn=1 with PC_Sel=1 if b, beq with Zero=1, or bne with Zero=0; else no PC load; then IFETCH.
REQ-017 lw/sw go EXEC -> MEM; Mem_Req=1 and Mem_WrEn=1 (sw only) held until Mem_Ack; sw then IFETCH, lw then WB.
REQ-018 WB: RF_WrEn=1 for exactly one cycle; RF_WrData_sel=1 for lw, 0 otherwise; then IFETCH.
REQ-019 Latency (Mem_Ack same cycle as request): branch 3, R-type/li/addi/sw 4, lw 5 cycles.
REQ-020 Timeout: wait counter counts cycles in IFETCH/MEM with Mem_Ack=0; reaching TIMEOUT -> FAULT; counter cleared on every state change.
REQ-021 FAULT: all control outputs 0, Fault=1, remains until Reset.
REQ-022 All outputs not explicitly asserted in a state SHALL be 0; Mem_WrEn never high outside MEM.
REQ-023 Mem_Ack outside IFETCH/MEM SHALL be ignored.

Reset
REQ-024 Reset in any state, including mid-MEM wait, SHALL next-cycle enter IFETCH with all outputs 0 except Mem_Req=1, Fault=0, wait counter 0.
REQ-025 Reset takes priority over Mem_Ack and timeout in the same cycle.

Configuration
REQ-026 Macro MULTICYCLE_SEQ_PERF_EN defined: outputs Cycle_Cnt[31:0] (cycles since reset, excluding FAULT) and Instr_Cnt[31:0] (incremented on each return to IFETCH), both wrapping at 2^32, cleared by Reset.
REQ-027 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package: state encoding, opcode constants, ALU_func constants (ADD=0000, SUB=0001), default TIMEOUT.
REQ-029 One sub-module natural: seq_timeout_cnt (loadable wait counter with terminal flag).

Verification
REQ-030 add R-type, Mem_Ack immediate -> states 0,1,2,4,0; RF_WrEn high one cycle in WB, ALU_func=Instr[3:0].
REQ-031 beq with Zero=1 then Zero=0 -> PC_LdEn&PC_Sel=1 in EXEC first case; PC_LdEn=0 second case; 3 cycles each.
REQ-032 lw with Mem_Ack delayed 3 cycles in MEM -> Mem_Req held 4 cycles, then WB with RF_WrData_sel=1, total 8 cycles.
REQ-033 Mem_Ack never asserted in IFETCH, TIMEOUT=16 -> FAULT after 16 cycles, Fault=1 sticky, Reset restores IFETCH.
REQ-034 Opcode 101010 -> FAULT after DECODE; Reset asserted during sw MEM wait -> IFETCH next cycle, Mem_WrEn=0.
REQ-035 With MULTICYCLE_SEQ_PERF_EN: 3 R-type instructions -> Instr_Cnt=3, Cycle_Cnt=12.
